// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: picks the next PC from sequential step, branch,
// call/return (through a circular return-address stack) or trap, with registered status pulses.
module pc_sequencer #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      RESET_VEC = '0,
    parameter logic [XLEN-1:0]      TRAP_VEC  = 'h100,
    parameter int unsigned          STEP      = 4,
    parameter int unsigned          RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         trap,
    input  logic                         branch_en,
    input  logic                         call_en,
    input  logic                         ret_en,
    input  logic [XLEN-1:0]              target,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              pc_next,
    output logic                         misaligned,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wp_q, wp_d;          // next free slot; top of stack is wp_q-1
    logic            mis_q, mis_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    logic            ras_we;
    logic [PW-1:0]   ras_waddr;
    logic [XLEN-1:0] ras_wdata;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] tgt_aligned;
    logic            tgt_mis;
    logic [PW-1:0]   top_idx;
    logic            ras_empty;
    logic            ras_full;

    always_comb begin
        seq_pc      = pc_q + XLEN'(STEP);
        tgt_aligned = target & ~LOW_MASK;
        tgt_mis     = |(target & LOW_MASK);
        top_idx     = wp_q - PW'(1);
        ras_empty   = (cnt_q == '0);
        ras_full    = (cnt_q == CW'(RAS_DEPTH));
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        wp_d      = wp_q;
        mis_d     = 1'b0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        ras_we    = 1'b0;
        ras_waddr = wp_q;
        ras_wdata = seq_pc;

        if (!stall) begin
            if (trap) begin
                pc_d = TRAP_VEC;
            end else if (ret_en && call_en) begin
                if (ras_empty) begin
                    // Nothing to return to: behave as a plain call and flag the underflow.
                    pc_d   = tgt_aligned;
                    mis_d  = tgt_mis;
                    unf_d  = 1'b1;
                    ras_we = 1'b1;
                    wp_d   = wp_q + PW'(1);
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    pc_d      = ras_q[top_idx];
                    ras_we    = 1'b1;
                    ras_waddr = top_idx;
                end
            end else if (ret_en) begin
                if (ras_empty) begin
                    pc_d  = seq_pc;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_q[top_idx];
                    wp_d  = top_idx;
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (call_en) begin
                // A full stack wraps and overwrites its oldest entry, which sits at wp_q.
                pc_d   = tgt_aligned;
                mis_d  = tgt_mis;
                ras_we = 1'b1;
                wp_d   = wp_q + PW'(1);
                if (ras_full) ovf_d = 1'b1;
                else          cnt_d = cnt_q + CW'(1);
            end else if (branch_en) begin
                pc_d  = tgt_aligned;
                mis_d = tgt_mis;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            cnt_q <= '0;
            wp_q  <= '0;
            mis_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            wp_q  <= wp_d;
            mis_q <= mis_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // NOTE: stack storage has no reset; entries are only ever read below the count, which is reset.
    always_ff @(posedge clk) begin
        if (ras_we) ras_q[ras_waddr] <= ras_wdata;
    end

    assign pc            = pc_q;
    assign pc_next       = pc_d;
    assign misaligned    = mis_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign ras_count     = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: reset, sequential stepping, branch alignment,
// call/return through the RAS including overflow/underflow, trap priority, stall and PC wrap.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        trap;
    logic        branch_en;
    logic        call_en;
    logic        ret_en;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        misaligned;
    logic        ras_overflow;
    logic        ras_underflow;
    logic [3:0]  ras_count;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .trap          (trap),
        .branch_en     (branch_en),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .target        (target),
        .pc            (pc),
        .pc_next       (pc_next),
        .misaligned    (misaligned),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .ras_count     (ras_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall     = 1'b0;
        trap      = 1'b0;
        branch_en = 1'b0;
        call_en   = 1'b0;
        ret_en    = 1'b0;
        target    = '0;
    endtask

    // Move the PC with an aligned branch (no pulses, RAS untouched).
    task automatic goto_pc(input logic [31:0] a);
        branch_en = 1'b1;
        target    = a;
        tick();
        branch_en = 1'b0;
    endtask

    task automatic check_pulses(input string tag, input logic m, input logic o, input logic u);
        check({tag, ".mis"}, 32'(misaligned),    32'(m));
        check({tag, ".ovf"}, 32'(ras_overflow),  32'(o));
        check({tag, ".unf"}, 32'(ras_underflow), 32'(u));
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check("rst.pc", pc, 32'h0);
        check("rst.cnt", 32'(ras_count), 32'd0);
        check_pulses("rst", 1'b0, 1'b0, 1'b0);

        // 1. reset release and idle stepping
        @(negedge clk);
        reset = 1'b0;
        check("seq.pc0", pc, 32'h0);
        check("seq.next0", pc_next, 32'h4);
        tick(); check("seq.pc1", pc, 32'h4);
        tick(); check("seq.pc2", pc, 32'h8);
        tick(); check("seq.pc3", pc, 32'hC);
        #2 reset = 1'b1;
        #1 check("arst.pc", pc, 32'h0);
        tick(); check("arst.hold", pc, 32'h0);
        reset = 1'b0;

        // 2. misaligned branch
        goto_pc(32'h10);
        check("br.start", pc, 32'h10);
        branch_en = 1'b1; target = 32'h83;
        #1 check("br.next", pc_next, 32'h80);
        tick();
        check("br.pc", pc, 32'h80);
        check_pulses("br", 1'b1, 1'b0, 1'b0);
        branch_en = 1'b0;
        tick();
        check("br.after", pc, 32'h84);
        check_pulses("br.after", 1'b0, 1'b0, 1'b0);

        // 3. call then return
        goto_pc(32'h20);
        call_en = 1'b1; target = 32'h400;
        tick();
        check("call.pc", pc, 32'h400);
        check("call.cnt", 32'(ras_count), 32'd1);
        call_en = 1'b0; ret_en = 1'b1;
        tick();
        check("ret.pc", pc, 32'h24);
        check("ret.cnt", 32'(ras_count), 32'd0);
        check_pulses("ret", 1'b0, 1'b0, 1'b0);
        ret_en = 1'b0;

        // 4. nine nested calls overflow an 8-deep RAS; nine returns drain it and underflow
        goto_pc(32'h1000);
        call_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            target = 32'h2000 + 32'(i) * 32'h100;
            tick();
            check($sformatf("nest.pc%0d", i), pc, 32'h2000 + 32'(i) * 32'h100);
            check($sformatf("nest.cnt%0d", i), 32'(ras_count), (i < 8) ? 32'(i + 1) : 32'd8);
            check($sformatf("nest.ovf%0d", i), 32'(ras_overflow), (i == 8) ? 32'd1 : 32'd0);
        end
        call_en = 1'b0; ret_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("unw.pc%0d", k), pc, 32'h2000 + 32'(7 - k) * 32'h100 + 32'h4);
            check($sformatf("unw.cnt%0d", k), 32'(ras_count), 32'(7 - k));
        end
        tick();
        check("unw.empty.pc", pc, 32'h2008);
        check("unw.empty.cnt", 32'(ras_count), 32'd0);
        check_pulses("unw.empty", 1'b0, 1'b0, 1'b1);
        ret_en = 1'b0;
        tick();
        check("unw.idle.pc", pc, 32'h200C);
        check_pulses("unw.idle", 1'b0, 1'b0, 1'b0);

        // 5. trap beats ret/call; combined ret+call swaps top; stall holds everything
        goto_pc(32'h3000);
        call_en = 1'b1; target = 32'h3100;
        tick();
        check("trap.setup.cnt", 32'(ras_count), 32'd1);
        trap = 1'b1; ret_en = 1'b1; target = 32'h3203;
        tick();
        check("trap.pc", pc, 32'h100);
        check("trap.cnt", 32'(ras_count), 32'd1);
        check_pulses("trap", 1'b0, 1'b0, 1'b0);
        trap = 1'b0;
        target = 32'h200;
        tick();
        check("swap.pc", pc, 32'h3004);
        check("swap.cnt", 32'(ras_count), 32'd1);
        call_en = 1'b0;
        stall = 1'b1; ret_en = 1'b0; branch_en = 1'b1; target = 32'h555;
        #1 check("stall.next", pc_next, 32'h3004);
        tick();
        check("stall.pc", pc, 32'h3004);
        check("stall.cnt", 32'(ras_count), 32'd1);
        check_pulses("stall", 1'b0, 1'b0, 1'b0);
        stall = 1'b0; branch_en = 1'b0; ret_en = 1'b1;
        tick();
        check("swap.ret.pc", pc, 32'h104);
        check("swap.ret.cnt", 32'(ras_count), 32'd0);
        ret_en = 1'b0;

        // 6. wrap at the top of the address space
        goto_pc(32'hFFFF_FFFC);
        tick();
        check("wrap.pc", pc, 32'h0);
        check_pulses("wrap", 1'b0, 1'b0, 1'b0);
        goto_pc(32'hFFFF_FFFC);
        call_en = 1'b1; target = 32'h40;
        tick();
        check("wrap.call.pc", pc, 32'h40);
        check("wrap.call.cnt", 32'(ras_count), 32'd1);
        call_en = 1'b0; ret_en = 1'b1;
        tick();
        check("wrap.ret.pc", pc, 32'h0);
        check("wrap.ret.cnt", 32'(ras_count), 32'd0);

        // ret+call on an empty RAS acts as a call and flags underflow
        call_en = 1'b1; target = 32'h51;
        tick();
        check("rc.empty.pc", pc, 32'h50);
        check("rc.empty.cnt", 32'(ras_count), 32'd1);
        check_pulses("rc.empty", 1'b1, 1'b0, 1'b1);
        clear_inputs();
        ret_en = 1'b1;
        tick();
        check("rc.empty.ret", pc, 32'h4);
        ret_en = 1'b0;

        // reset asserted while stalled
        stall = 1'b1;
        #2 reset = 1'b1;
        #1 check("rst.stall.pc", pc, 32'h0);
        check("rst.stall.cnt", 32'(ras_count), 32'd0);
        reset = 1'b0;
        stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
